// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures the period of div_in in clk cycles, counts edges, flags loss.
// Optional period_min/period_max tracking is compiled in when MON_MINMAX_EN is defined.
module div_clk_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned EDGE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C1,
    input  logic              div_in,
    output logic [CNT_W-1:0]  period,
    output logic              period_vld,
    input  logic              period_rdy,
    output logic              overrun,
    output logic              lost,
    output logic [EDGE_W-1:0] edge_cnt
`ifdef MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0]  period_min,
    output logic [CNT_W-1:0]  period_max
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        LOST       = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic              r_rise;
    logic [CNT_W-1:0]  r_run;
    logic [CNT_W-1:0]  r_period;
    logic              r_vld;
    logic              r_overrun;
    logic              r_lost;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0]  r_min;
    logic [CNT_W-1:0]  r_max;
    logic              w_emit;
    logic              w_timeout;

    // Synchronizer and registered rising-edge detector; run regardless of C1
    // so re-enabling with div_in already high does not fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= div_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign w_emit    = (r_state == MEASURE) && r_rise;
    assign w_timeout = (r_run == TIMEOUT_C);

    // Control FSM with run counter, handshake and edge counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_run      <= '0;
            r_period   <= '0;
            r_vld      <= 1'b0;
            r_overrun  <= 1'b0;
            r_lost     <= 1'b0;
            r_edge_cnt <= '0;
            r_min      <= '1;
            r_max      <= '0;
        end else if (!C1) begin
            r_state    <= IDLE;
            r_run      <= '0;
            r_vld      <= 1'b0;
            r_overrun  <= 1'b0;
            r_lost     <= 1'b0;
            r_edge_cnt <= '0;
            r_min      <= '1;
            r_max      <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_run <= '0;
            end else if (r_rise) begin
                r_run <= CNT_W'(1);
            end else if (!w_timeout) begin
                r_run <= r_run + CNT_W'(1);
            end

            // A fresh measurement wins over a same-cycle accept.
            if (w_emit) begin
                r_period <= r_run;
                r_vld    <= 1'b1;
                if (r_vld && !period_rdy) begin
                    r_overrun <= 1'b1;
                end
                if (r_run < r_min) begin
                    r_min <= r_run;
                end
                if (r_run > r_max) begin
                    r_max <= r_run;
                end
            end else if (r_vld && period_rdy) begin
                r_vld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_state <= WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (r_rise) begin
                        r_state    <= MEASURE;
                        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                    end else if (w_timeout) begin
                        r_state <= LOST;
                        r_lost  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (r_rise) begin
                        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                    end else if (w_timeout) begin
                        r_state <= LOST;
                        r_lost  <= 1'b1;
                    end
                end
                LOST: begin
                    if (r_rise) begin
                        r_state    <= MEASURE;
                        r_lost     <= 1'b0;
                        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign period_vld = r_vld;
    assign overrun    = r_overrun;
    assign lost       = r_lost;
    assign edge_cnt   = r_edge_cnt;

`ifdef MON_MINMAX_EN
    assign period_min = r_min;
    assign period_max = r_max;
`else
    logic w_unused_minmax;
    assign w_unused_minmax = ^{r_min, r_max};
`endif

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Sits directly downstream of the frequency divider and consumes its divided clock output as an ordinary data signal sampled in the `clk` domain.
- Measures the divided-clock period in `clk` cycles, counts rising edges, and flags loss of the divided clock.
- Presents each period measurement on a valid/ready output for the status/readout logic.
- Shares the divider's `C1` mode enable, so the monitor runs only while the divider runs.

Parameters:
- CNT_W, 16: width of period counter and `period` output.
- TIMEOUT, 64: clk cycles without a synchronized rising edge before `lost` asserts. Legal range 2 .. 2^CNT_W-1.
- EDGE_W, 8: width of `edge_cnt`.

Ports:
- clk  input  1  system clock; same clock as the divider.
- rst  input  1  asynchronous, active-low reset; all flops clear immediately when rst=0.
- C1  input  1  mode enable, same meaning as at the divider. 0 = block idle.
- div_in  input  1  divided clock from the divider (`clockout`), treated as asynchronous data.
- period  output  CNT_W  last measured period, in clk cycles.
- period_vld  output  1  `period` holds an unconsumed measurement.
- period_rdy  input  1  consumer accepts `period` when `period_vld` && `period_rdy`.
- overrun  output  1  sticky: a measurement was overwritten before it was accepted.
- lost  output  1  no rising edge within TIMEOUT cycles.
- edge_cnt  output  EDGE_W  rising edges seen since enable; wraps at 2^EDGE_W.

Behaviour:

Reset (rst=0):
- period=0, period_vld=0, overrun=0, lost=0, edge_cnt=0.
- Synchronizer flops=0, run counter=0, state=IDLE.

Input path:
- `div_in` passes through a 2-flop synchronizer, then a registered edge detector.
- A rising edge on `div_in` produces `rise` 3 clk cycles later.

Run counter `run`:
- On a `rise` cycle, `run`<=1.
- Otherwise `run`<=`run`+1, saturating at TIMEOUT.
- A square wave of period P yields `run`=P on the next `rise`.

States:
- IDLE: `run`=0; outputs held at their reset values.
  - C1=1 -> WAIT_FIRST.
- WAIT_FIRST: waiting for the first edge.
  - `rise` -> MEASURE, edge_cnt+1, no period emitted.
  - `run`==TIMEOUT -> LOST.
- MEASURE:
  - `rise` -> period<=`run`, period_vld<=1, edge_cnt+1.
  - `run`==TIMEOUT without `rise` -> LOST.
- LOST: lost=1.
  - `rise` -> MEASURE, lost<=0, edge_cnt+1, no period emitted (the interval is invalid).
- Any state: C1=0 -> IDLE next cycle. This clears period_vld, overrun, lost, edge_cnt and `run`; `period` keeps its value.

Handshake:
- `period_vld` && `period_rdy` -> period_vld<=0, unless a new measurement lands in the same cycle. In that case the new value loads and period_vld stays 1; this is not an overrun.
- New measurement while `period_vld`=1 and `period_rdy`=0 -> period overwritten, period_vld stays 1, overrun<=1.
- `overrun` clears only on reset or C1=0.
- `period` is stable while period_vld=1, except when overwritten as above.

Other rules:
- `edge_cnt` wraps from 2^EDGE_W-1 to 0 silently.
- Reset asserted mid-measurement: everything returns to reset values asynchronously. After release the block restarts in IDLE, or goes to WAIT_FIRST if C1=1.
- The first measurement after enable or after LOST always needs two valid edges.

Optional Feature:
- Macro: MON_MINMAX_EN.
- When defined:
  - Adds outputs `period_min` and `period_max` (CNT_W each).
  - On each emitted measurement: period_min<=min(period_min, new), period_max<=max(period_max, new).
  - Reset and C1=0 set period_min to all-ones and period_max to 0.
  - LOST does not alter them.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, C1=1, `div_in` driven like the divider (period 8 clk, 4 high/4 low), `period_rdy`=1 -> first `period_vld` pulse after the second rising edge + 3 cycles with period=8; thereafter one pulse every 8 cycles, edge_cnt incrementing by 1 per edge.
2. Same stimulus, `period_rdy`=0 for 20 cycles -> period_vld held, period=8, overrun=1 after the second unaccepted measurement. `period_rdy`=1 -> period_vld drops, overrun stays 1.
3. `div_in` held low 70 cycles after MEASURE -> lost=1 exactly when `run` reaches 64. Restart period-8 wave -> lost=0 at the first `rise`, no period emitted, next period=8.
4. C1 dropped mid-run -> next cycle period_vld=0, lost=0, edge_cnt=0, overrun=0. C1 reasserted -> WAIT_FIRST, first valid after two edges.
5. rst pulsed low between edges with period_vld=1 -> all outputs 0 immediately, without a clk edge; measurement restarts cleanly.
6. With MON_MINMAX_EN: periods 8, 12, 6 -> period_min=6, period_max=12. Without the macro, the build has no such ports.
